mem_bus_bridge: RTL and testbench

//  Downstream of cpu: converts its single-cycle memory port (addr/rd/wr/wrdata/rddata) into an

---
 rtl/mem_bridge_pkg.sv | 10 +
 rtl/bus_timeout_ctr.sv | 19 +
 rtl/mem_bus_bridge.sv | 93 +++++++++
 tb/tb_mem_bus_bridge.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared types and defaults for the cpu-to-Avalon memory bridge.
package mem_bridge_pkg;
    typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;
    localparam int unsigned DEF_TIMEOUT = 255;
    localparam logic [15:0] DEF_ERR_RDDATA = 16'h0000;
    function automatic int ctr_width(input int unsigned t);
        return (t < 256) ? 8 : $clog2(t + 1);
    endfunction
endpackage

// File: rtl/bus_timeout_ctr.sv
// bus_timeout_ctr: saturating cycle counter that flags the cycle in which it reaches limit.
module bus_timeout_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset || clear) cnt <= '0;
        else if (enable && cnt != '1) cnt <= cnt + W'(1);
    end
    // Fires in the cycle whose increment would reach the limit; a zero limit disables it.
    assign expired = enable && limit != '0 && ({1'b0, cnt} + (W+1)'(1) >= {1'b0, limit});
endmodule

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: stalls a single-cycle cpu memory port while one Avalon-MM access
// (waitrequest, variable read latency) completes, aborting hung accesses on timeout.
module mem_bus_bridge import mem_bridge_pkg::*; #(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT,
    parameter logic [15:0] ERR_RDDATA     = DEF_ERR_RDDATA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_rd,
    input  logic        i_cpu_wr,
    input  logic [15:0] i_cpu_wrdata,
    output logic [15:0] o_cpu_rddata,
    output logic        o_cpu_rddata_valid,
    output logic        o_cpu_stall,
    output logic        o_err,
    output logic [15:0] o_avm_address,
    output logic        o_avm_read,
    output logic        o_avm_write,
    output logic [15:0] o_avm_writedata,
    input  logic        i_avm_waitrequest,
    input  logic [15:0] i_avm_readdata,
    input  logic        i_avm_readdatavalid
);
    localparam int CW = ctr_width(TIMEOUT_CYCLES);
    state_t state;
    op_t op;
    logic req, start, busy, expired, abort;
    logic [CW-1:0] limit;
    assign limit = CW'(TIMEOUT_CYCLES);
    assign req = i_cpu_rd || i_cpu_wr;
    assign start = state == IDLE && req;
    assign busy = state == CMD || state == RESP;
    assign o_cpu_stall = busy || start;
    // Completion in the same cycle as expiry takes precedence over the abort.
    assign abort = expired && ((state == CMD && i_avm_waitrequest) || (state == RESP && !i_avm_readdatavalid));

    bus_timeout_ctr #(.W(CW)) u_timeout (
        .clk(clk), .reset(reset), .clear(start), .enable(busy), .limit(limit), .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op <= OP_RD;
            o_cpu_rddata <= '0;
            o_cpu_rddata_valid <= 1'b0;
            o_err <= 1'b0;
            o_avm_address <= '0;
            o_avm_read <= 1'b0;
            o_avm_write <= 1'b0;
            o_avm_writedata <= '0;
        end else begin
            o_cpu_rddata_valid <= 1'b0;
            o_err <= 1'b0;
            if (abort) begin
                o_avm_read <= 1'b0;
                o_avm_write <= 1'b0;
                o_cpu_rddata <= ERR_RDDATA;
                o_err <= 1'b1;
                o_cpu_rddata_valid <= op == OP_RD;
                state <= DONE;
            end else begin
                case (state)
                    IDLE: if (req) begin
                        op <= i_cpu_wr ? OP_WR : OP_RD;
                        o_avm_address <= i_cpu_addr;
                        o_avm_writedata <= i_cpu_wrdata;
                        o_avm_write <= i_cpu_wr;
                        o_avm_read <= !i_cpu_wr;
                        state <= CMD;
                    end
                    CMD: if (!i_avm_waitrequest) begin
                        o_avm_read <= 1'b0;
                        o_avm_write <= 1'b0;
                        if (op == OP_WR) state <= DONE;
                        else if (i_avm_readdatavalid) begin
                            o_cpu_rddata <= i_avm_readdata;
                            o_cpu_rddata_valid <= 1'b1;
                            state <= DONE;
                        end else state <= RESP;
                    end
                    RESP: if (i_avm_readdatavalid) begin
                        o_cpu_rddata <= i_avm_readdata;
                        o_cpu_rddata_valid <= 1'b1;
                        state <= DONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge: directed cycle-by-cycle checks of the bridge with an 8-cycle timeout.
module tb_mem_bus_bridge;
    logic clk = 1'b0, reset = 1'b1;
    logic [15:0] cpu_addr = '0, cpu_wrdata = '0, avm_readdata = '0;
    logic cpu_rd = 1'b0, cpu_wr = 1'b0, avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
    logic [15:0] cpu_rddata, avm_address, avm_writedata;
    logic cpu_rddata_valid, cpu_stall, err, avm_read, avm_write;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_bus_bridge #(.TIMEOUT_CYCLES(8), .ERR_RDDATA(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .i_cpu_addr(cpu_addr), .i_cpu_rd(cpu_rd), .i_cpu_wr(cpu_wr), .i_cpu_wrdata(cpu_wrdata),
        .o_cpu_rddata(cpu_rddata), .o_cpu_rddata_valid(cpu_rddata_valid), .o_cpu_stall(cpu_stall),
        .o_err(err), .o_avm_address(avm_address), .o_avm_read(avm_read), .o_avm_write(avm_write),
        .o_avm_writedata(avm_writedata), .i_avm_waitrequest(avm_waitrequest),
        .i_avm_readdata(avm_readdata), .i_avm_readdatavalid(avm_readdatavalid)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_stall", cpu_stall, 0);
        chk("rst_read", avm_read, 0);
        chk("rst_write", avm_write, 0);
        chk("rst_rddata", cpu_rddata, 16'h0000);
        chk("rst_valid", cpu_rddata_valid, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        tick();
        // zero-wait write
        cpu_wr = 1'b1; cpu_addr = 16'h0040; cpu_wrdata = 16'hBEEF;
        #1 chk("t1_c0_stall", cpu_stall, 1);
        chk("t1_c0_write", avm_write, 0);
        tick();
        chk("t1_c1_write", avm_write, 1);
        chk("t1_c1_addr", avm_address, 16'h0040);
        chk("t1_c1_wdata", avm_writedata, 16'hBEEF);
        chk("t1_c1_stall", cpu_stall, 1);
        chk("t1_c1_read", avm_read, 0);
        tick();
        chk("t1_c2_write", avm_write, 0);
        chk("t1_c2_stall", cpu_stall, 0);
        chk("t1_c2_valid", cpu_rddata_valid, 0);
        cpu_wr = 1'b0;
        tick();
        chk("t1_c3_write", avm_write, 0);
        // read with 3 waitrequest cycles, data two cycles after acceptance
        cpu_rd = 1'b1; cpu_addr = 16'h0010; avm_waitrequest = 1'b1;
        #1 chk("t2_c0_stall", cpu_stall, 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("t2_wait_read", avm_read, 1);
            chk("t2_wait_addr", avm_address, 16'h0010);
            chk("t2_wait_stall", cpu_stall, 1);
        end
        tick();
        avm_waitrequest = 1'b0;
        chk("t2_acc_read", avm_read, 1);
        chk("t2_acc_addr", avm_address, 16'h0010);
        tick();
        chk("t2_resp_read", avm_read, 0);
        chk("t2_resp_stall", cpu_stall, 1);
        chk("t2_resp_valid", cpu_rddata_valid, 0);
        tick();
        avm_readdatavalid = 1'b1; avm_readdata = 16'h1234;
        chk("t2_resp2_stall", cpu_stall, 1);
        tick();
        avm_readdatavalid = 1'b0;
        chk("t2_done_valid", cpu_rddata_valid, 1);
        chk("t2_done_data", cpu_rddata, 16'h1234);
        chk("t2_done_stall", cpu_stall, 0);
        chk("t2_done_err", err, 0);
        cpu_rd = 1'b0;
        tick();
        chk("t2_idle_valid", cpu_rddata_valid, 0);
        chk("t2_idle_data", cpu_rddata, 16'h1234);
        // read accepted with data in the same cycle
        cpu_rd = 1'b1; cpu_addr = 16'h0020;
        tick();
        avm_readdatavalid = 1'b1; avm_readdata = 16'hABCD;
        chk("t3_cmd_read", avm_read, 1);
        tick();
        avm_readdatavalid = 1'b0;
        chk("t3_done_valid", cpu_rddata_valid, 1);
        chk("t3_done_data", cpu_rddata, 16'hABCD);
        chk("t3_done_read", avm_read, 0);
        chk("t3_done_stall", cpu_stall, 0);
        cpu_rd = 1'b0;
        tick();
        chk("t3_idle_valid", cpu_rddata_valid, 0);
        // waitrequest stuck: abort after 8 cycles in CMD
        cpu_rd = 1'b1; cpu_addr = 16'h0030; avm_waitrequest = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("t4_hang_read", avm_read, 1);
            chk("t4_hang_err", err, 0);
        end
        tick();
        chk("t4_abort_err", err, 1);
        chk("t4_abort_valid", cpu_rddata_valid, 1);
        chk("t4_abort_data", cpu_rddata, 16'h0000);
        chk("t4_abort_read", avm_read, 0);
        chk("t4_abort_stall", cpu_stall, 0);
        cpu_rd = 1'b0; avm_waitrequest = 1'b0;
        tick();
        chk("t4_idle_err", err, 0);
        chk("t4_idle_valid", cpu_rddata_valid, 0);
        cpu_wr = 1'b1; cpu_addr = 16'h0050; cpu_wrdata = 16'h1111;
        tick();
        chk("t4_next_write", avm_write, 1);
        chk("t4_next_addr", avm_address, 16'h0050);
        tick();
        chk("t4_next_done_write", avm_write, 0);
        chk("t4_next_done_err", err, 0);
        cpu_wr = 1'b0;
        tick();
        // rd and wr together: write wins
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h0002; cpu_wrdata = 16'h5555;
        tick();
        chk("t5_both_write", avm_write, 1);
        chk("t5_both_read", avm_read, 0);
        chk("t5_both_addr", avm_address, 16'h0002);
        tick();
        chk("t5_both_valid", cpu_rddata_valid, 0);
        chk("t5_both_err", err, 0);
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        tick();
        // reset while waiting for read data
        cpu_rd = 1'b1; cpu_addr = 16'h0060;
        tick();
        chk("t5_rd_read", avm_read, 1);
        tick();
        chk("t5_resp_read", avm_read, 0);
        chk("t5_resp_stall", cpu_stall, 1);
        reset = 1'b1; cpu_rd = 1'b0;
        tick();
        chk("t5_rst_stall", cpu_stall, 0);
        chk("t5_rst_read", avm_read, 0);
        chk("t5_rst_data", cpu_rddata, 16'h0000);
        reset = 1'b0;
        avm_readdatavalid = 1'b1; avm_readdata = 16'hDEAD;
        tick();
        avm_readdatavalid = 1'b0;
        chk("t5_late_valid", cpu_rddata_valid, 0);
        chk("t5_late_data", cpu_rddata, 16'h0000);
        chk("t5_late_stall", cpu_stall, 0);
        tick();
        chk("t5_after_valid", cpu_rddata_valid, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
